bit_serializer: RTL

Parallel-to-serial front end for the serial pattern-detector FSMs. It accepts DATA_W-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clk, on a single-bit stream. The detector's serial input x connects directly to ser_out. A one-word holding buffer allows back-to-back words to stream with no idle bit between them.

---
 rtl/bit_ser_pkg.sv | 16 +
 rtl/bit_ser_hold.sv | 45 ++++
 rtl/bit_serializer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/bit_ser_pkg.sv
// bit_ser_pkg: shared types and constants for the bit_serializer block.
//   state_t        : serializer FSM states (PARITY only used when BIT_SER_PARITY_EN is defined)
//   DATA_W_DEFAULT : default word width
//   IDLE_LINE      : value driven on ser_out while no word is being sent
package bit_ser_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam logic        IDLE_LINE      = 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

endpackage

// File: rtl/bit_ser_hold.sv
// bit_ser_hold: single-entry holding buffer in front of the shifter.
// Ports:
//   clk, rst_n  : clock, async active-low reset
//   in_data     : word offered by the source
//   in_valid    : source handshake valid
//   in_ready    : buffer can accept this cycle (from registered state and take only)
//   take        : shifter consumes the held word on this edge
//   hold_data   : held word
//   hold_full   : held word is valid
module bit_ser_hold
  import bit_ser_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              take,
  output logic [DATA_W-1:0] hold_data,
  output logic              hold_full
);

  logic [DATA_W-1:0] data_q;
  logic              full_q;

  // A take frees the slot on the same edge, so a new word may enter while the old one leaves.
  assign in_ready  = !full_q || take;
  assign hold_data = data_q;
  assign hold_full = full_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else if (in_valid && in_ready) begin
      data_q <= in_data;
      full_q <= 1'b1;
    end else if (take) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end, MSB first, one bit per clk.
// Optional feature macro: BIT_SER_PARITY_EN appends one even-parity bit per word.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   in_data    : DATA_W-bit word to serialize
//   in_valid   : in_data valid
//   in_ready   : block can accept a word this cycle
//   ser_out    : serial bit (idle line 0)
//   ser_valid  : ser_out carries a data/parity bit
//   word_done  : high while the final bit of a word is on ser_out
//   busy       : shifter or hold buffer occupied
module bit_serializer
  import bit_ser_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ser_out,
  output logic              ser_valid,
  output logic              word_done,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              load_now;
  logic              last_bit;
  logic [DATA_W-1:0] hold_data;
  logic              hold_full;
`ifdef BIT_SER_PARITY_EN
  logic              par_q, par_d;
`endif

  bit_ser_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .take      (load_now),
    .hold_data (hold_data),
    .hold_full (hold_full)
  );

  assign last_bit = (cnt_q == LAST_IDX);
  assign busy     = hold_full || (state_q != IDLE);

  // State, shifter and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
`ifdef BIT_SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
`ifdef BIT_SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state, load decision and serial outputs.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    load_now  = 1'b0;
    ser_out   = IDLE_LINE;
    ser_valid = 1'b0;
    word_done = 1'b0;
`ifdef BIT_SER_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      IDLE: begin
        if (hold_full) load_now = 1'b1;
      end
      SHIFT: begin
        ser_out   = shreg_q[DATA_W-1];
        ser_valid = 1'b1;
        shreg_d   = shreg_q << 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (last_bit) begin
          cnt_d = '0;
`ifdef BIT_SER_PARITY_EN
          state_d = PARITY;
`else
          word_done = 1'b1;
          if (hold_full) load_now = 1'b1;
          else           state_d  = IDLE;
`endif
        end
      end
`ifdef BIT_SER_PARITY_EN
      PARITY: begin
        ser_out   = par_q;
        ser_valid = 1'b1;
        word_done = 1'b1;
        if (hold_full) load_now = 1'b1;
        else           state_d  = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Loading overrides the shift/count update so a held word abuts the previous one.
    if (load_now) begin
      shreg_d = hold_data;
      cnt_d   = '0;
      state_d = SHIFT;
`ifdef BIT_SER_PARITY_EN
      par_d   = ^hold_data;
`endif
    end
  end

endmodule
